// File: rtl/axi4l_regbank.sv
// axi4l_regbank: generic AXI4-Lite control/status register bank.
// RW registers take byte-strobed writes, RO registers mirror regs_i, bad accesses get error responses.
module axi4l_regbank #(
  parameter int                       NREGS     = 4,
  parameter int                       DATA_W    = 32,
  parameter int                       ADDR_W    = 4,
  parameter logic [NREGS-1:0]         RO_MASK   = {NREGS{1'b0}},
  parameter logic [NREGS*DATA_W-1:0]  RESET_VAL = {NREGS*DATA_W{1'b0}}
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic [2:0]               awprot,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic [2:0]               arprot,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic [NREGS*DATA_W-1:0]  regs_o,
  input  logic [NREGS*DATA_W-1:0]  regs_i,
  output logic [NREGS-1:0]         wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} rstate_t;

  function automatic int reg_index(input logic [ADDR_W-1:0] a);
    return int'(a[ADDR_W-1:OFF_W]);
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int k = 0; k < STRB_W; k++) begin
      res[k*8 +: 8] = strb[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
    end
    return res;
  endfunction

  // RO slots never hold state, so their flops reset to zero and stay there.
  function automatic logic [NREGS*DATA_W-1:0] rw_reset_value();
    logic [NREGS*DATA_W-1:0] v;
    v = RESET_VAL;
    for (int i = 0; i < NREGS; i++) begin
      v[i*DATA_W +: DATA_W] = RO_MASK[i] ? {DATA_W{1'b0}} : RESET_VAL[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  localparam logic [NREGS*DATA_W-1:0] REG_RST = rw_reset_value();

  wstate_t                  wstate_q, wstate_d;
  rstate_t                  rstate_q, rstate_d;
  logic                     aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0]        awaddr_q, awaddr_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic [STRB_W-1:0]        wstrb_q, wstrb_d;
  logic                     bvalid_q, bvalid_d;
  logic [1:0]               bresp_q, bresp_d;
  logic [NREGS-1:0]         wr_pulse_q, wr_pulse_d;
  logic [NREGS*DATA_W-1:0]  regs_q, regs_d;
  logic                     rvalid_q, rvalid_d;
  logic [DATA_W-1:0]        rdata_q, rdata_d;
  logic [1:0]               rresp_q, rresp_d;
  logic [NREGS-1:0]         wr_hit_s;
  logic                     wr_ok_s, wr_ro_s, rd_hit_s;
  logic [DATA_W-1:0]        rd_word_s;
  logic                     unused_s;

  assign awready    = (wstate_q == W_IDLE) && !aw_held_q;
  assign wready     = (wstate_q == W_IDLE) && !w_held_q;
  assign arready    = (rstate_q == R_IDLE);
  assign bvalid     = bvalid_q;
  assign bresp      = bresp_q;
  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign rresp      = rresp_q;
  assign regs_o     = regs_q;
  assign wr_pulse_o = wr_pulse_q;
  assign unused_s   = ^{awprot, arprot, awaddr_q[OFF_W-1:0], araddr[OFF_W-1:0], regs_i};

  // Decode of the latched write address into a one-hot register hit.
  always_comb begin
    wr_hit_s = {NREGS{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      wr_hit_s[i] = (reg_index(awaddr_q) == i);
    end
    wr_ok_s = |(wr_hit_s & ~RO_MASK);
    wr_ro_s = |(wr_hit_s & RO_MASK);
  end

  // Write FSM: collect AW and W independently, execute once, then hold the response.
  always_comb begin
    wstate_d   = wstate_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = {NREGS{1'b0}};
    regs_d     = regs_q;
    case (wstate_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end else begin
          aw_held_d = aw_held_q;
        end
        if (wvalid && wready) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end else begin
          w_held_d = w_held_q;
        end
        if (aw_held_d && w_held_d) begin
          wstate_d = W_EXEC;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_EXEC: begin
        if (wr_ok_s) begin
          bresp_d    = RESP_OKAY;
          wr_pulse_d = wr_hit_s & {NREGS{|wstrb_q}};
        end else if (wr_ro_s) begin
          bresp_d = RESP_SLVERR;
        end else begin
          bresp_d = RESP_DECERR;
        end
        for (int i = 0; i < NREGS; i++) begin
          regs_d[i*DATA_W +: DATA_W] = (wr_hit_s[i] && !RO_MASK[i])
            ? merge_bytes(regs_q[i*DATA_W +: DATA_W], wdata_q, wstrb_q)
            : regs_q[i*DATA_W +: DATA_W];
        end
        bvalid_d = 1'b1;
        wstate_d = W_RESP;
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          wstate_d  = W_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      default: begin
        wstate_d = W_IDLE;
      end
    endcase
  end

  // Read mux: stored value for RW slots, live status for RO slots, zero when unmapped.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    rd_hit_s  = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      rd_hit_s  = rd_hit_s | (reg_index(araddr) == i);
      rd_word_s = rd_word_s | ({DATA_W{reg_index(araddr) == i}} &
                  (RO_MASK[i] ? regs_i[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W]));
    end
  end

  // Read FSM: capture data at the AR handshake and hold it until rready.
  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: begin
        if (arvalid) begin
          rdata_d  = rd_word_s;
          rresp_d  = rd_hit_s ? RESP_OKAY : RESP_DECERR;
          rvalid_d = 1'b1;
          rstate_d = R_RESP;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        rstate_d = R_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      wstate_q   <= W_IDLE;
      rstate_q   <= R_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
      wstrb_q    <= {STRB_W{1'b0}};
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      wr_pulse_q <= {NREGS{1'b0}};
      regs_q     <= REG_RST;
      rvalid_q   <= 1'b0;
      rdata_q    <= {DATA_W{1'b0}};
      rresp_q    <= 2'b00;
    end else begin
      wstate_q   <= wstate_d;
      rstate_q   <= rstate_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// tb_axi4l_regbank: directed and randomized checks of axi4l_regbank against a word/byte model.
// Five address bits give four mapped registers (0x00-0x0F) plus an unmapped upper half.
module tb_axi4l_regbank;
  localparam int NREGS = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [3:0] RO = 4'b1000;
  localparam logic [127:0] RST = {32'h0000_0000, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};

  logic         aclk = 1'b0;
  logic         areset_n = 1'b0;
  logic         awvalid = 1'b0, awready;
  logic [4:0]   awaddr = 5'h00;
  logic [2:0]   awprot = 3'b000;
  logic         wvalid = 1'b0, wready;
  logic [31:0]  wdata = 32'h0;
  logic [3:0]   wstrb = 4'h0;
  logic         bvalid, bready = 1'b0;
  logic [1:0]   bresp;
  logic         arvalid = 1'b0, arready;
  logic [4:0]   araddr = 5'h00;
  logic [2:0]   arprot = 3'b000;
  logic         rvalid, rready = 1'b0;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [127:0] regs_o;
  logic [127:0] regs_i = 128'h0;
  logic [3:0]   wr_pulse_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] model [NREGS];

  always #5 aclk = ~aclk;

  axi4l_regbank #(
    .NREGS(NREGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RO_MASK(RO), .RESET_VAL(RST)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regs_o), .regs_i(regs_i), .wr_pulse_o(wr_pulse_o)
  );

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = RST[i*32 +: 32];
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] v;
    for (int i = 0; i < NREGS; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : model[i];
    return v;
  endfunction

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [2:0] idx3;
    logic [1:0] idx;
    logic [1:0] e_resp;
    logic [3:0] e_pulse;
    int t;
    bit aw_done, w_done, aw_fire, w_fire;
    idx3 = addr[4:2];
    idx = idx3[1:0];
    e_pulse = 4'b0000;
    if (idx3 >= 3'd4) e_resp = 2'b11;
    else if (RO[idx]) e_resp = 2'b10;
    else begin
      e_resp = 2'b00;
      if (strb != 4'b0000) e_pulse = 4'b0001 << idx;
      for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = data[k*8 +: 8];
    end
    t = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && t < 50) begin
      awvalid = !aw_done && (t >= aw_dly);
      awaddr = addr;
      wvalid = !w_done && (t >= w_dly);
      wdata = data;
      wstrb = strb;
      if (w_done && !aw_done) begin
        n_cmp++;
        if (wready !== 1'b0) begin n_fail++; $display("FAIL w_held_wready: got %b want 0", wready); end
      end
      if (aw_done && !w_done) begin
        n_cmp++;
        if (awready !== 1'b0) begin n_fail++; $display("FAIL aw_held_awready: got %b want 0", awready); end
      end
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      @(posedge aclk);
      aw_done = aw_done | aw_fire;
      w_done = w_done | w_fire;
      @(negedge aclk);
      t++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    n_cmp++;
    if (!(aw_done && w_done)) begin
      n_fail++; $display("FAIL wr_handshake_timeout: aw %b w %b want 1 1", aw_done, w_done);
      return;
    end
    n_cmp++;
    if ({bvalid, awready, wready} !== 3'b000) begin
      n_fail++; $display("FAIL wr_exec: bvalid/awready/wready got %b want 000", {bvalid, awready, wready});
    end
    @(posedge aclk); @(negedge aclk);
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== e_resp) begin
      n_fail++; $display("FAIL wr_bresp addr %h: got bvalid %b bresp %b want 1 %b", addr, bvalid, bresp, e_resp);
    end
    n_cmp++;
    if (wr_pulse_o !== e_pulse) begin
      n_fail++; $display("FAIL wr_pulse addr %h: got %b want %b", addr, wr_pulse_o, e_pulse);
    end
    n_cmp++;
    if (regs_o !== model_flat()) begin
      n_fail++; $display("FAIL wr_regs addr %h: got %h want %h", addr, regs_o, model_flat());
    end
    for (int c = 0; c < b_dly; c++) begin
      @(posedge aclk); @(negedge aclk);
      n_cmp++;
      if ({bvalid, bresp, wr_pulse_o, awready, wready} !== {1'b1, e_resp, 4'b0000, 2'b00}) begin
        n_fail++;
        $display("FAIL wr_bhold: got bv %b bresp %b pulse %b awr %b wr %b want 1 %b 0000 0 0",
                 bvalid, bresp, wr_pulse_o, awready, wready, e_resp);
      end
    end
    bready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0;
    n_cmp++;
    if ({bvalid, wr_pulse_o, awready, wready} !== {1'b0, 4'b0000, 2'b11}) begin
      n_fail++;
      $display("FAIL wr_done: got bv %b pulse %b awr %b wr %b want 0 0000 1 1", bvalid, wr_pulse_o, awready, wready);
    end
  endtask

  task automatic do_read(input logic [4:0] addr, input int r_dly, output logic [31:0] got);
    logic [2:0] idx3;
    logic [1:0] idx;
    logic [31:0] e_data;
    logic [1:0] e_resp;
    idx3 = addr[4:2];
    idx = idx3[1:0];
    if (idx3 >= 3'd4) begin e_data = 32'h0; e_resp = 2'b11; end
    else if (RO[idx]) begin e_data = regs_i[idx*32 +: 32]; e_resp = 2'b00; end
    else begin e_data = model[idx]; e_resp = 2'b00; end
    n_cmp++;
    if (arready !== 1'b1) begin n_fail++; $display("FAIL rd_arready: got %b want 1", arready); end
    arvalid = 1'b1;
    araddr = addr;
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    n_cmp++;
    if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, e_resp, e_data}) begin
      n_fail++;
      $display("FAIL rd_data addr %h: got rv %b arr %b rresp %b rdata %h want 1 0 %b %h",
               addr, rvalid, arready, rresp, rdata, e_resp, e_data);
    end
    for (int c = 0; c < r_dly; c++) begin
      @(posedge aclk); @(negedge aclk);
      n_cmp++;
      if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, e_resp, e_data}) begin
        n_fail++;
        $display("FAIL rd_hold addr %h: got rv %b arr %b rresp %b rdata %h want 1 0 %b %h",
                 addr, rvalid, arready, rresp, rdata, e_resp, e_data);
      end
    end
    got = rdata;
    rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    rready = 1'b0;
    n_cmp++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++; $display("FAIL rd_done: got rv %b arr %b want 0 1", rvalid, arready);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got;
    areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    model_reset();
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b want 111", {awready, wready, arready});
    end
    n_cmp++;
    if ({bvalid, rvalid, bresp, rresp, wr_pulse_o, rdata} !== 42'h0) begin
      n_fail++; $display("FAIL reset_outputs: got bv %b rv %b bresp %b rresp %b pulse %b rdata %h want all 0",
                         bvalid, rvalid, bresp, rresp, wr_pulse_o, rdata);
    end
    n_cmp++;
    if (regs_o[63:32] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL reset_reg1: got %h want deadbeef", regs_o[63:32]);
    end
    do_read(5'h04, 0, got);
    n_cmp++;
    if (got !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL reset_read1: got %h want deadbeef", got); end
  endtask

  task automatic test_write_strobe();
    do_write(5'h00, 32'h1122_3344, 4'hF, 0, 0, 0);
    n_cmp++;
    if (regs_o[31:0] !== 32'h1122_3344) begin n_fail++; $display("FAIL strobe_full: got %h want 11223344", regs_o[31:0]); end
    do_write(5'h00, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    n_cmp++;
    if (regs_o[31:0] !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_partial: got %h want 11bb33dd", regs_o[31:0]); end
    do_write(5'h04, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
  endtask

  task automatic test_w_before_aw();
    do_write(5'h08, 32'h0BAD_F00D, 4'hF, 3, 0, 4);
    n_cmp++;
    if (regs_o[95:64] !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL w_first_reg2: got %h want 0badf00d", regs_o[95:64]); end
    do_write(5'h09, 32'h1357_9BDF, 4'b1100, 0, 2, 1);
  endtask

  task automatic test_read_only();
    logic [31:0] got;
    regs_i[127:96] = 32'h0000_CAFE;
    do_write(5'h0C, 32'h1234_5678, 4'hF, 0, 0, 0);
    do_read(5'h0C, 1, got);
    n_cmp++;
    if (got !== 32'h0000_CAFE) begin n_fail++; $display("FAIL ro_read: got %h want 0000cafe", got); end
  endtask

  task automatic test_unmapped();
    logic [31:0] got;
    do_write(5'h10, 32'h5555_AAAA, 4'hF, 0, 0, 1);
    do_read(5'h10, 0, got);
    do_write(5'h1F, 32'h0000_00FF, 4'h1, 1, 0, 0);
    do_read(5'h1C, 2, got);
  endtask

  task automatic test_collision();
    logic [31:0] old_v;
    logic [31:0] new_v;
    old_v = model[0];
    new_v = ~old_v;
    awvalid = 1'b1; awaddr = 5'h00; wvalid = 1'b1; wdata = new_v; wstrb = 4'hF;
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 5'h00;
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    model[0] = new_v;
    n_cmp++;
    if (rvalid !== 1'b1 || rdata !== old_v) begin
      n_fail++; $display("FAIL collide_rdata: got rv %b rdata %h want 1 %h", rvalid, rdata, old_v);
    end
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== 2'b00 || regs_o !== model_flat()) begin
      n_fail++; $display("FAIL collide_write: got bv %b bresp %b regs %h want 1 00 %h", bvalid, bresp, regs_o, model_flat());
    end
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    n_cmp++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      n_fail++; $display("FAIL collide_done: got %b want 00111", {bvalid, rvalid, awready, wready, arready});
    end
  endtask

  task automatic test_reset_mid();
    awvalid = 1'b1; awaddr = 5'h04; wvalid = 1'b1; wdata = 32'h5A5A_5A5A; wstrb = 4'hF;
    @(posedge aclk); @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 5'h0C;
    @(posedge aclk); @(negedge aclk);
    arvalid = 1'b0;
    n_cmp++;
    if ({bvalid, rvalid} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_pre: got %b want 11", {bvalid, rvalid}); end
    areset_n = 1'b0;
    @(posedge aclk); @(negedge aclk);
    model_reset();
    n_cmp++;
    if ({bvalid, rvalid, awready, wready, arready, wr_pulse_o, bresp, rresp} !== 13'b00_111_0000_00_00) begin
      n_fail++; $display("FAIL rst_mid_flags: got bv %b rv %b rdy %b pulse %b bresp %b rresp %b want 0 0 111 0000 00 00",
                         bvalid, rvalid, {awready, wready, arready}, wr_pulse_o, bresp, rresp);
    end
    n_cmp++;
    if (regs_o !== model_flat() || rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_regs: got regs %h rdata %h want %h 0", regs_o, rdata, model_flat());
    end
    areset_n = 1'b1;
    @(posedge aclk); @(negedge aclk);
    n_cmp++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111) begin
      n_fail++; $display("FAIL rst_mid_dropped: got %b want 00111", {bvalid, rvalid, awready, wready, arready});
    end
  endtask

  task automatic test_random();
    logic [31:0] got;
    for (int it = 0; it < 60; it++) begin
      regs_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0)
        do_write(5'($urandom_range(0, 31)), $urandom(), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(5'($urandom_range(0, 31)), $urandom_range(0, 2), got);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_strobe();
    test_w_before_aw();
    test_read_only();
    test_unmapped();
    test_collision();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axi4l_regbank.md
Name: axi4l_regbank

Overview:
- Parametrised AXI4-Lite slave register bank: NREGS word registers of DATA_W bits.
- Each register is either read/write, with per-byte write strobes, or read-only, mirroring a status input.
- Decodes unmapped accesses and illegal writes into AXI error responses.
- Used as the generic control/status register block behind the interconnect, replacing fixed two-register slaves.

Parameters:
- NREGS, 4, number of registers; 1..256.
- DATA_W, 32, register/bus data width; 32 or 64.
- ADDR_W, 4, AXI address width; must be >= clog2(NREGS)+clog2(DATA_W/8).
- RO_MASK, {NREGS{1'b0}}, bit i = 1 makes register i read-only.
- RESET_VAL, {NREGS*DATA_W{1'b0}}, flattened reset values; register i at bits [i*DATA_W +: DATA_W].

Ports:
- aclk  in  1  clock
- areset_n  in  1  reset
- awvalid/awready  in/out  1  AW handshake
- awaddr  in  ADDR_W  write byte address
- awprot  in  3  ignored
- wvalid/wready  in/out  1  W handshake
- wdata  in  DATA_W  write data
- wstrb  in  DATA_W/8  byte enables
- bvalid/bready  out/in  1  B handshake
- bresp  out  2  write response
- arvalid/arready  in/out  1  AR handshake
- araddr  in  ADDR_W  read byte address
- arprot  in  3  ignored
- rvalid/rready  out/in  1  R handshake
- rdata  out  DATA_W  read data
- rresp  out  2  read response
- regs_o  out  NREGS*DATA_W  flattened RW register contents (RO slots drive 0)
- regs_i  in  NREGS*DATA_W  flattened status inputs, read for RO registers
- wr_pulse_o  out  NREGS  one-cycle pulse per register on a successful write

Behaviour:
- Reset: areset_n, synchronous, active-low.
- On reset:
  - all handshake flags clear; both FSMs go to IDLE.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, wr_pulse_o=0.
  - awready=1, wready=1 and arready=1 from the first cycle after reset.
  - RW registers load RESET_VAL.
- Reset mid-transaction drops the transaction; no response is issued.
- Address decode:
  - index = addr[ADDR_W-1 : clog2(DATA_W/8)].
  - The low byte-offset bits are ignored.
  - index >= NREGS is unmapped.
- Write FSM states: IDLE, EXEC, RESP.
  - IDLE: awready = !aw_held and wready = !w_held.
  - AW and W are accepted independently, in any order or in the same cycle; awaddr is latched into aw_held and wdata/wstrb into w_held.
  - When both are held (including at the edge where the second one arrives), go to EXEC.
  - In EXEC, awready=0 and wready=0.
  - At the end of EXEC, go to RESP and set bvalid<=1.
  - Unmapped address: bresp=2'b11 (DECERR), no update.
  - RO register: bresp=2'b10 (SLVERR), no update.
  - Otherwise: bresp=2'b00; each byte with wstrb[k]=1 is replaced and the others are kept.
  - Otherwise, wr_pulse_o[index]<=1 for one cycle if wstrb != 0; wstrb=0 gives OKAY with no pulse.
  - RESP: bvalid, bresp and wr_pulse_o are registered together, so the new value on regs_o, the pulse and bvalid all appear in the same cycle.
  - bvalid and bresp are held until bready; on bvalid&bready go to IDLE and clear both held flags.
  - Minimum timing: AW+W handshake at edge 0, bvalid at edge 2. With bready tied high, awready and wready are high again from edge 3.
- Read FSM states: IDLE, RESP.
  - IDLE: arready=1. On arvalid&arready, at the same edge: rdata<=selected value, rresp set, rvalid<=1, go to RESP.
  - Selected value: stored value for RW registers, regs_i slice for RO registers.
  - Unmapped address: rdata=0, rresp=2'b11.
  - RESP: arready=0; rdata, rresp and rvalid are stable until rready.
  - On rvalid&rready go to IDLE; arready is high the next cycle.
  - Read latency is 1 cycle.
- Read and write channels are fully independent and may be active concurrently.
- Read/write collision: a read sampled before or at the same edge as the EXEC update returns the old value.

Test Plan:
- Test configuration: NREGS=4, DATA_W=32, ADDR_W=4, RO_MASK=4'b1000, RESET_VAL reg1=0xDEADBEEF, all others 0.
- Reset, then read addr 0x4 -> rdata=0xDEADBEEF, rresp=00, rvalid one cycle after the AR handshake; regs_o reg1=0xDEADBEEF.
- Write 0x0 data 0x11223344 strb 4'hF, AW and W in the same cycle, bready=1 -> bvalid 2 cycles later, bresp=00, wr_pulse_o=4'b0001 for 1 cycle, reg0=0x11223344. Then write strb 4'b0101 data 0xAABBCCDD -> reg0=0x11BB33DD.
- W 3 cycles before AW, with bready held low for 4 cycles -> wready=0 after the W handshake; bvalid held with stable bresp; awready/wready stay 0 until the B handshake, then return to 1.
- Write to 0xC (RO) with regs_i reg3=0x0000CAFE -> bresp=10, no pulse; read 0xC -> 0x0000CAFE, rresp=00.
- ADDR_W=5: write and read 0x10 -> bresp=11, rresp=11, rdata=0, no register changes.
- Assert areset_n=0 while bvalid=1 and rvalid=1 -> next cycle bvalid=0, rvalid=0, regs at RESET_VAL, all ready signals 1.
